// File: rtl/alu_sequencer_pkg.sv
// Package control: shared types and constants for the ALU sequencer.
//   alu_op_e          - operation code driven to the external ALU
//   alu_flag_e        - status flag returned by the external ALU
//   seq_state_e       - sequencer FSM state encoding
//   ALU_SETTLE_CYCLES - cycles operands are held before the result is sampled
//   ALU_IDLE_OP       - opcode presented to the ALU while no operation runs
package control;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5,
        ALU_DIV = 3'd6
    } alu_op_e;

    typedef enum logic [1:0] {
        FLAG_NONE      = 2'd0,
        FLAG_ZERO      = 2'd1,
        FLAG_REMAINDER = 2'd2,
        FLAG_OVERFLOW  = 2'd3
    } alu_flag_e;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_ISSUE   = 2'd1,
        SEQ_CAPTURE = 2'd2,
        SEQ_RESP    = 2'd3
    } seq_state_e;

    localparam int unsigned ALU_SETTLE_CYCLES = 2;
    localparam int unsigned SETTLE_W          = 2;
    localparam alu_op_e     ALU_IDLE_OP       = ALU_NOP;

endpackage

// File: rtl/alu_sequencer_arbiter.sv
// alu_arbiter: two-requester grant selection for the ALU sequencer.
// Build option: ALU_SEQ_RR_EN defined -> round-robin against last_grant_i;
// undefined -> fixed priority, requester 0 always wins.
// Ports:
//   valid_i      in  2  request valid per requester
//   enable_i     in  1  grants allowed this cycle (sequencer idle)
//   last_grant_i in  1  ID of the most recently accepted requester
//   grant_o      out 2  one-hot grant, zero when disabled or no request
//   grant_id_o   out 1  index of the granted requester
module alu_arbiter (
    input  logic [1:0] valid_i,
    input  logic       enable_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    always_comb begin
        grant_id_o = 1'b0;
`ifdef ALU_SEQ_RR_EN
        if (valid_i == 2'b11) begin
            grant_id_o = ~last_grant_i;
        end else begin
            grant_id_o = ~valid_i[0];
        end
`else
        grant_id_o = ~valid_i[0];
`endif
        grant_o = 2'b00;
        if (enable_i && (valid_i != 2'b00)) begin
            grant_o = grant_id_o ? 2'b10 : 2'b01;
        end
    end

`ifndef ALU_SEQ_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one operation from two requesters, drives it onto an
// external ALU for ALU_SETTLE_CYCLES, samples the result and returns it as a
// one-cycle response to the issuing requester.
// Build option: ALU_SEQ_RR_EN selects round-robin arbitration (see alu_arbiter).
// Ports:
//   clock, reset_n           system clock / async active-low reset
//   req_valid/req_ready      per-requester handshake (ready only in IDLE)
//   req_op, req_a, req_b     per-requester operation and operands
//   resp_valid               one-cycle completion pulse to the issuer
//   resp_data, resp_flag     last captured ALU result and flag
//   alu_op, alu_register1/2  operation/operands to the ALU
//   alu_out                  one-cycle capture strobe
//   alu_result, alu_flag     ALU outputs
//   busy                     high whenever not IDLE
//
// state   | meaning
// IDLE    | waiting for a request; grant and latch payload
// ISSUE   | operands driven to ALU, settle counter running
// CAPTURE | alu_out strobe, result/flag sampled
// RESP    | resp_valid pulse to the issuing requester
module alu_sequencer
    import control::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  alu_op_e    req_op [2],
    input  logic [7:0] req_a [2],
    input  logic [7:0] req_b [2],
    output logic [1:0] resp_valid,
    output logic [7:0] resp_data,
    output alu_flag_e  resp_flag,
    output alu_op_e    alu_op,
    output logic [7:0] alu_register1,
    output logic [7:0] alu_register2,
    output logic       alu_out,
    input  logic [7:0] alu_result,
    input  alu_flag_e  alu_flag,
    output logic       busy
);

    seq_state_e          state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    alu_op_e             op_q, op_d;
    logic [7:0]          a_q, a_d, b_q, b_d;
    logic                id_q, id_d;
    logic [7:0]          data_q, data_d;
    alu_flag_e           flag_q, flag_d;

    logic [1:0] grant;
    logic       grant_id;
    logic       last_grant;
    logic       accept;

    alu_arbiter u_arbiter (
        .valid_i      (req_valid),
        .enable_i     (state_q == SEQ_IDLE),
        .last_grant_i (last_grant),
        .grant_o      (grant),
        .grant_id_o   (grant_id)
    );

    // The grant is only asserted against a valid request, so it is the handshake.
    assign accept = |grant;

`ifdef ALU_SEQ_RR_EN
    logic last_grant_q;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= grant_id;
        end
    end
    assign last_grant = last_grant_q;
`else
    assign last_grant = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SEQ_IDLE;
            settle_q <= '0;
            op_q     <= ALU_IDLE_OP;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            id_q     <= 1'b0;
            data_q   <= 8'h00;
            flag_q   <= FLAG_NONE;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            data_q   <= data_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        data_d   = data_q;
        flag_d   = flag_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (accept) begin
                    op_d     = req_op[grant_id];
                    a_d      = req_a[grant_id];
                    b_d      = req_b[grant_id];
                    id_d     = grant_id;
                    settle_d = SETTLE_W'(ALU_SETTLE_CYCLES - 1);
                    state_d  = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                if (settle_q == '0) begin
                    state_d = SEQ_CAPTURE;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            SEQ_CAPTURE: begin
                data_d  = alu_result;
                flag_d  = alu_flag;
                state_d = SEQ_RESP;
            end
            SEQ_RESP: begin
                state_d = SEQ_IDLE;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    logic driving;
    assign driving = (state_q == SEQ_ISSUE) || (state_q == SEQ_CAPTURE);

    assign req_ready     = grant;
    assign busy          = (state_q != SEQ_IDLE);
    assign alu_op        = driving ? op_q : ALU_IDLE_OP;
    assign alu_register1 = driving ? a_q : 8'h00;
    assign alu_register2 = driving ? b_q : 8'h00;
    assign alu_out       = (state_q == SEQ_CAPTURE);
    assign resp_valid    = (state_q == SEQ_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_data     = data_q;
    assign resp_flag     = flag_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, rising edge; all state updates on posedge clock.
REQ-002 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req_valid  in  2  per-requester request valid, bit i = requester i.
REQ-004 SHALL have ports: req_ready  out  2  per-requester grant/accept, at most one bit high.
REQ-005 SHALL have ports: req_op  in  2 x alu_op_e  requested operation per requester.
REQ-006 SHALL have ports: req_a, req_b  in  2 x 8  operands per requester.
REQ-007 SHALL have ports: resp_valid  out  2  one-cycle completion pulse to the requester that issued.
REQ-008 SHALL have ports: resp_data  out  8  captured ALU result; resp_flag  out  alu_flag_e  captured ALU flag.
REQ-009 SHALL have ports: alu_op  out  alu_op_e; alu_register1, alu_register2  out  8; alu_out  out  1.
REQ-010 SHALL have ports: alu_result  in  8; alu_flag  in  alu_flag_e.
REQ-011 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP.
REQ-013 IDLE: any req_valid -> grant one requester, drive its req_ready high combinationally that cycle, latch its op/operands and ID, go ISSUE.
REQ-014 Handshake = req_valid[i] & req_ready[i]; requester holds valid and payload stable until accepted; req_ready SHALL be 0 outside IDLE.
REQ-015 ISSUE: drive latched op/operands on alu_op/alu_register1/alu_register2 for exactly ALU_SETTLE_CYCLES (=2) cycles, then go CAPTURE.
REQ-016 CAPTURE: alu_out=1 for one cycle, alu_op held, sample alu_result and alu_flag into response registers, go RESP.
REQ-017 RESP: resp_valid[ID]=1 for exactly one cycle with resp_data/resp_flag valid; go IDLE; no grant in RESP.
REQ-018 Latency: accept cycle N -> resp_valid at cycle N+4; max throughput one op per 5 cycles.
REQ-019 Outside ISSUE/CAPTURE: alu_op=ALU_IDLE_OP, alu_register1=alu_register2=0, alu_out=0.
REQ-020 resp_data/resp_flag SHALL hold last captured values until next CAPTURE.
REQ-021 Operands passed unmodified, 8-bit; no arithmetic inside block; DIV by zero forwarded as-is.
REQ-022 req_valid deasserted after accept SHALL NOT affect an in-flight operation.

Reset
REQ-023 reset_n low SHALL immediately force IDLE; req_ready=0 (until first IDLE evaluation), resp_valid=0, resp_data=0, resp_flag=NONE, alu_out=0, alu_op=ALU_IDLE_OP, busy=0, last_grant=1.
REQ-024 Reset mid-operation SHALL discard the in-flight op with no resp_valid pulse.

Configuration
REQ-025 Macro ALU_SEQ_RR_EN defined: round-robin; when both valid, grant requester != last_grant; last_grant updated on every accept.
REQ-026 ALU_SEQ_RR_EN undefined: fixed priority, requester 0 always wins; last_grant unused.

Structure
REQ-027 ALU_SETTLE_CYCLES, ALU_IDLE_OP and the sequencer state typedef SHALL live in package control alongside alu_op_e/alu_flag_e.
REQ-028 Grant logic SHALL be a sub-module alu_arbiter (2 requesters, macro-selectable policy); FSM and datapath in alu_sequencer.

Verification
REQ-029 Single: req_valid=01, op ADD, a=0x12, b=0x34 -> ready[0] same cycle, resp_valid=01 four cycles later, resp_data=0x46, flag NONE.
REQ-030 Carry/zero: ADD 0xFF+0x01 -> resp_data=0x00, resp_flag=ZERO; SUB 0x05-0x05 -> 0x00, ZERO.
REQ-031 Contention, RR on: both valid continuously, 4 ops -> grants 0,1,0,1; RR off -> 0,0,0,0 and requester 1 starves.
REQ-032 Back-to-back: requester 1 valid during RESP -> not accepted until following IDLE cycle; ready never high outside IDLE.
REQ-033 Reset mid-op: assert reset_n low in ISSUE -> no resp_valid, busy=0, alu_out=0; next request completes normally.
REQ-034 DIV: 0x09/0x02 -> resp_data=0x04, resp_flag=REMAINDER; alu_op held stable through CAPTURE.
